parity_stream_checker: RTL

Streaming, parametrised successor to the team's 4-bit combinational even-parity checker. Accepts a valid/ready stream of DATA_W-bit words, each with a received parity bit. Checks every word against a runtime-selectable even/odd parity and aggregates the results into fixed-length frames. Keeps a saturating error counter and a sticky error flag. Sits between a serial-link deserialiser and downstream consumers, with one registered output stage.

---
 rtl/parity_stream_checker_pkg.sv | 24 ++
 rtl/parity_stream_checker_sat_counter.sv | 45 ++++
 rtl/parity_stream_checker.sv | 128 ++++++++++++
 3 files changed

// File: rtl/parity_stream_checker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : parity_pkg
// Description : Shared parity constants and helpers for the parity stream
//               checker and future parity generator blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package parity_pkg;

    // Value on odd_mode selecting each parity sense
    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    // Widest word the helper accepts; narrower words are zero-extended,
    // which leaves the reduction XOR unchanged
    localparam int PARITY_MAX_W = 256;

    // Reduction XOR: 1 when the word holds an odd number of ones
    function automatic logic calc_parity(input logic [PARITY_MAX_W-1:0] word);
        return ^word;
    endfunction

endpackage
`default_nettype wire

// File: rtl/parity_stream_checker_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Saturating up-counter with synchronous clear. A clear and an
//               increment in the same cycle leave the count at one.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] C_MAX = '1;

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_base;
    logic [CNT_W-1:0] w_next;

    // Clear takes effect before the increment is applied; hold at all-ones
    always_comb begin
        w_base = clr ? '0 : r_count;
        w_next = w_base;
        if (inc && (w_base != C_MAX)) begin
            w_next = w_base + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else begin
            r_count <= w_next;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/parity_stream_checker.sv
`default_nettype none
// ============================================================================
// Module      : parity_stream_checker
// Description : Valid/ready streaming parity checker. Checks each accepted
//               word against even/odd parity, groups words into fixed-length
//               frames, and keeps a saturating error count plus sticky flag.
//               One registered output stage.
// Revision    : 1.0 - initial release
// ============================================================================
module parity_stream_checker
    import parity_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int FRAME_LEN = 4,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_pbit,
    input  logic              odd_mode,
    input  logic              resync,
    input  logic              clr_err,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_word_err,
    output logic              out_frame_last,
    output logic              out_frame_err,
    output logic [CNT_W-1:0]  err_count,
    output logic              err_sticky
);

    localparam int              IDX_W      = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(FRAME_LEN - 1);

    logic [IDX_W-1:0]  r_idx;
    logic              r_acc;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_word_err;
    logic              r_out_frame_last;
    logic              r_out_frame_err;
    logic              r_sticky;

    logic              w_accept;
    logic              w_xfer;
    logic              w_word_err;
    logic [IDX_W-1:0]  w_eff_idx;
    logic              w_eff_acc;
    logic              w_is_last;

    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;
    assign w_xfer   = r_out_valid && out_ready;

    // Per-word check plus the frame position this word lands on; resync makes
    // the current word the first of a fresh frame
    always_comb begin
        w_word_err = calc_parity(PARITY_MAX_W'(in_data)) ^ in_pbit ^ (odd_mode == PARITY_ODD);
        w_eff_idx  = resync ? '0 : r_idx;
        w_eff_acc  = resync ? 1'b0 : r_acc;
        w_is_last  = (w_eff_idx == C_LAST_IDX);
    end

    // Frame index and frame-error accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
            r_acc <= 1'b0;
        end else if (w_accept) begin
            r_idx <= w_is_last ? '0 : w_eff_idx + 1'b1;
            r_acc <= w_is_last ? 1'b0 : (w_eff_acc | w_word_err);
        end else if (resync) begin
            r_idx <= '0;
            r_acc <= 1'b0;
        end
    end

    // Output stage: load on accept, drop valid on a bare transfer, else hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid      <= 1'b0;
            r_out_data       <= '0;
            r_out_word_err   <= 1'b0;
            r_out_frame_last <= 1'b0;
            r_out_frame_err  <= 1'b0;
        end else if (w_accept) begin
            r_out_valid      <= 1'b1;
            r_out_data       <= in_data;
            r_out_word_err   <= w_word_err;
            r_out_frame_last <= w_is_last;
            r_out_frame_err  <= w_is_last && (w_eff_acc | w_word_err);
        end else if (w_xfer) begin
            r_out_valid      <= 1'b0;
        end
    end

    // Sticky error flag; a new error wins over a same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky <= 1'b0;
        end else begin
            r_sticky <= (clr_err ? 1'b0 : r_sticky) | (w_accept && w_word_err);
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_err),
        .inc   (w_accept && w_word_err),
        .count (err_count)
    );

    assign out_valid      = r_out_valid;
    assign out_data       = r_out_data;
    assign out_word_err   = r_out_word_err;
    assign out_frame_last = r_out_frame_last;
    assign out_frame_err  = r_out_frame_err;
    assign err_sticky     = r_sticky;

endmodule
`default_nettype wire
